// File: rtl/seq_mul_32_if.sv
// Bundle of handshake and data signals between an operand source/result sink
// and the sequential multiplier.
//   master : drives in_valid, A, B, is_signed, out_ready; observes the rest
//   slave  : the multiplier side (accepts operands, returns P/ZF/OF, busy)
interface seq_mul_32_if #(
  parameter int WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic                 is_signed;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   P;
  logic                 ZF;
  logic                 OF;
  logic                 busy;

  modport master (
    output in_valid, A, B, is_signed, out_ready,
    input  in_ready, out_valid, P, ZF, OF, busy
  );

  modport slave (
    input  in_valid, A, B, is_signed, out_ready,
    output in_ready, out_valid, P, ZF, OF, busy
  );
endinterface

// File: rtl/seq_mul_32.sv
// Multi-cycle shift-and-add multiplier. One partial-product add per cycle
// (accumulator high half + gated multiplicand), signed operands handled by
// magnitude multiply followed by a two's-complement fix-up.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active-high
//   bus  : seq_mul_32_if.slave
//          in_valid/in_ready   operand handshake (ready only in IDLE)
//          A, B, is_signed     multiplicand, multiplier, signedness
//          out_valid/out_ready result handshake
//          P, ZF, OF           2*WIDTH product, zero flag, overflow flag
//          busy                high in RUN or FIX
module seq_mul_32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic        clk,
  input logic        rst,
  seq_mul_32_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 neg_q;
  logic                 sgn_q;
  logic [2*WIDTH-1:0]   p_q;
  logic                 zf_q;
  logic                 of_q;
  logic                 ov_q;

  // Datapath registers: contents are don't-care until an accept reloads them.
  logic [WIDTH-1:0]     mcand_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;

  logic                 accept_w;
  logic [WIDTH:0]       sum_w;
  logic [2*WIDTH-1:0]   p_fix_w;

  // Magnitude of an operand; the most-negative value maps to 2**(W-1),
  // which is representable as an unsigned W-bit number.
  function automatic logic [WIDTH-1:0] abs_op(input logic signed [WIDTH-1:0] v,
                                              input logic sgn);
    logic signed [WIDTH-1:0] n;
    n = -v;
    return (sgn && v[WIDTH-1]) ? n : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_fix(input logic [2*WIDTH-1:0] acc,
                                                 input logic neg);
    return neg ? (~acc + 1'b1) : acc;
  endfunction

  // Unsigned: any bit in the upper half. Signed: upper half plus the result
  // sign bit must be a pure sign extension.
  function automatic logic of_flag(input logic [2*WIDTH-1:0] p,
                                   input logic sgn);
    logic [WIDTH:0] top;
    top = p[2*WIDTH-1:WIDTH-1];
    if (sgn)
      return !((top == '0) || (top == '1));
    else
      return (p[2*WIDTH-1:WIDTH] != '0);
  endfunction

  assign accept_w = (state_q == S_IDLE) && bus.in_valid;

  // Adder carry is kept as bit WIDTH so the unsigned 2W-bit result is exact.
  assign sum_w   = {1'b0, hi_q} + {1'b0, mcand_q & {WIDTH{lo_q[0]}}};
  assign p_fix_w = neg_fix({hi_q, lo_q}, neg_q);

  // State register and control/result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      sgn_q   <= 1'b0;
      p_q     <= '0;
      zf_q    <= 1'b0;
      of_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept_w) begin
        neg_q <= bus.is_signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
        sgn_q <= bus.is_signed;
      end
      if (state_q == S_FIX) begin
        p_q  <= p_fix_w;
        zf_q <= (p_fix_w == '0);
        of_q <= of_flag(p_fix_w, sgn_q);
      end
      // The result registers settle for one cycle in DONE before out_valid
      // is raised; release clears it on the handshake edge.
      if (state_q == S_DONE) begin
        if (!ov_q)
          ov_q <= 1'b1;
        else if (bus.out_ready)
          ov_q <= 1'b0;
      end
    end
  end

  // Shift-and-add datapath
  always_ff @(posedge clk) begin
    if (accept_w) begin
      mcand_q <= abs_op(bus.A, bus.is_signed);
      lo_q    <= abs_op(bus.B, bus.is_signed);
      hi_q    <= '0;
    end else if (state_q == S_RUN) begin
      // {c, hi, lo} >> 1 : the consumed multiplier bit falls off lo[0].
      hi_q <= sum_w[WIDTH:1];
      lo_q <= {sum_w[0], lo_q[WIDTH-1:1]};
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          state_d = S_RUN;
          cnt_d   = CNT_W'(WIDTH);
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1))
          state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        if (ov_q && bus.out_ready)
          state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    bus.in_ready  = (state_q == S_IDLE);
    bus.busy      = (state_q == S_RUN) || (state_q == S_FIX);
    bus.out_valid = ov_q;
    bus.P         = p_q;
    bus.ZF        = zf_q;
    bus.OF        = of_q;
  end

endmodule

// File: tb/tb_seq_mul_32.sv
module tb_seq_mul_32;

  localparam int W = 32;

  logic clk;
  logic rst;

  seq_mul_32_if #(.WIDTH(W)) bus ();

  seq_mul_32 #(.WIDTH(W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] p;
    logic        zf;
    logic        of;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Waits for in_ready, presents operands for one accept edge, scrambles the
  // inputs afterwards, then waits for out_valid. lat = edges after accept.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [63:0] p, output logic zf, output logic of,
                       output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_accept", {63'd0, bus.in_ready}, 64'd1);
    bus.A = a;
    bus.B = b;
    bus.is_signed = s;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.A = ~a;
    bus.B = $urandom;
    bus.is_signed = ~s;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.out_valid && lat < 200);
    p  = bus.P;
    zf = bus.ZF;
    of = bus.OF;
  endtask

  task automatic release_result(input int gap);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("out_valid_after_release", {63'd0, bus.out_valid}, 64'd0);
    chk("in_ready_after_release", {63'd0, bus.in_ready}, 64'd1);
  endtask

  logic [63:0] p;
  logic        zf, of;
  int          lat;
  logic [31:0] ra, rb;
  logic        rs;
  logic signed [63:0] sp;
  logic [63:0] ep;
  logic        eof;

  initial begin
    total = 0;
    bad   = 0;
    vecs[0]  = '{32'd7,          32'd6,          1'b0, 64'd42,                 1'b0, 1'b0};
    vecs[1]  = '{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 64'hFFFFFFFE00000001,   1'b0, 1'b1};
    vecs[2]  = '{32'hFFFFFFFD,   32'd5,          1'b1, 64'hFFFFFFFFFFFFFFF1,   1'b0, 1'b0};
    vecs[3]  = '{32'h80000000,   32'h80000000,   1'b1, 64'h4000000000000000,   1'b0, 1'b1};
    vecs[4]  = '{32'd0,          32'd12345,      1'b0, 64'd0,                  1'b1, 1'b0};
    vecs[5]  = '{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b1, 64'd1,                  1'b0, 1'b0};
    vecs[6]  = '{32'h80000000,   32'd1,          1'b1, 64'hFFFFFFFF80000000,   1'b0, 1'b0};
    vecs[7]  = '{32'h80000000,   32'hFFFFFFFF,   1'b1, 64'h0000000080000000,   1'b0, 1'b1};
    vecs[8]  = '{32'd10000,      32'd10000,      1'b0, 64'h0000000005F5E100,   1'b0, 1'b0};
    vecs[9]  = '{32'h00010000,   32'h00010000,   1'b0, 64'h0000000100000000,   1'b0, 1'b1};
    vecs[10] = '{32'h7FFFFFFF,   32'd2,          1'b1, 64'h00000000FFFFFFFE,   1'b0, 1'b1};
    vecs[11] = '{32'h7FFFFFFF,   32'd2,          1'b0, 64'h00000000FFFFFFFE,   1'b0, 1'b0};
    vecs[12] = '{32'd0,          32'hFFFFFFFD,   1'b1, 64'd0,                  1'b1, 1'b0};

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.is_signed = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_P", bus.P, 64'd0);
    chk("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("reset_ZF", {63'd0, bus.ZF}, 64'd0);
    chk("reset_OF", {63'd0, bus.OF}, 64'd0);
    chk("reset_busy", {63'd0, bus.busy}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 13; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].s, p, zf, of, lat);
      chk($sformatf("latency[%0d]", i), 64'(lat), 64'd34);
      chk($sformatf("P[%0d]", i), p, vecs[i].p);
      chk($sformatf("ZF[%0d]", i), {63'd0, zf}, {63'd0, vecs[i].zf});
      chk($sformatf("OF[%0d]", i), {63'd0, of}, {63'd0, vecs[i].of});
      release_result(0);
    end

    // Backpressure: result must hold while out_ready stays low
    do_op(32'd0, 32'd12345, 1'b0, p, zf, of, lat);
    chk("bp_P", p, 64'd0);
    chk("bp_ZF", {63'd0, zf}, 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_P", bus.P, 64'd0);
      chk("bp_hold_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("bp_hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
    end
    // in_valid together with out_ready in DONE must not be accepted
    @(negedge clk);
    bus.A = 32'd9;
    bus.B = 32'd9;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("release_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("release_no_accept_busy", {63'd0, bus.busy}, 64'd0);
    bus.in_valid = 1'b0;

    // Reset in the middle of RUN, with a nonzero result still on P
    do_op(32'd7, 32'd6, 1'b0, p, zf, of, lat);
    chk("pre_reset_P", p, 64'd42);
    release_result(0);
    @(negedge clk);
    bus.A = 32'd100;
    bus.B = 32'd100;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("mid_run_busy", {63'd0, bus.busy}, 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_P", bus.P, 64'd0);
    chk("rst_mid_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_mid_busy", {63'd0, bus.busy}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_in_ready", {63'd0, bus.in_ready}, 64'd1);
    do_op(32'd2, 32'd3, 1'b0, p, zf, of, lat);
    chk("post_reset_P", p, 64'd6);
    chk("post_reset_latency", 64'(lat), 64'd34);
    release_result(1);

    // Random operands against an arithmetic model, random release gaps
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 5 == 0) rb = {16'd0, rb[15:0]};
      rs = i[0];
      if (rs) begin
        sp  = $signed(ra) * $signed(rb);
        ep  = sp;
        eof = (sp > 64'sd2147483647) || (sp < -64'sd2147483648);
      end else begin
        ep  = {32'd0, ra} * {32'd0, rb};
        eof = ep > 64'h00000000FFFFFFFF;
      end
      do_op(ra, rb, rs, p, zf, of, lat);
      chk("rnd_P", p, ep);
      chk("rnd_ZF", {63'd0, zf}, {63'd0, ep == 64'd0});
      chk("rnd_OF", {63'd0, of}, {63'd0, eof});
      chk("rnd_latency", 64'(lat), 64'd34);
      release_result(int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
